// File: rtl/ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// ps2_rx_fifo
// PS/2 keyboard receiver. It synchronises and deglitches the PS/2 clock and
// frames 11-bit packets (start, 8 data LSB first, odd parity, stop). Good
// bytes go into a first-word-fall-through FIFO and into a HIST-byte history
// register. Parity, framing, overflow and watchdog errors are sticky flags.
//
// Optional feature macro: PS2_TIMEOUT_EN adds a frame watchdog. Without it,
// timeout is tied to 0.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   ps2_clk        PS/2 clock pin (asynchronous)
//   ps2_data       PS/2 data pin (asynchronous)
//   rd             pop request; ignored when the FIFO is empty
//   err_clr        clears all sticky flags; a set in the same cycle wins
//   dout           FIFO head byte; valid while !empty, 0 when empty
//   empty, full    FIFO status
//   count          FIFO occupancy, 0..DEPTH
//   code           history of accepted bytes, newest byte in the top 8 bits
//   parity_err     sticky: a frame failed odd parity
//   frame_err      sticky: a frame had stop bit = 0
//   overflow       sticky: a byte was dropped because the FIFO was full
//   timeout        sticky: the watchdog aborted a frame
// ---------------------------------------------------------------------------
module ps2_rx_fifo #(
   parameter int DEPTH          = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 4,
   parameter int HIST           = 2,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ps2_clk,
   input  logic                     ps2_data,
   input  logic                     rd,
   input  logic                     err_clr,
   output logic [7:0]               dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic [8*HIST-1:0]        code,
   output logic                     parity_err,
   output logic                     frame_err,
   output logic                     overflow,
   output logic                     timeout
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // ------------------------------------------------------------------
   // Pin synchronisers (reset to the idle-high line level)
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] clk_sync_reg;
   logic [SYNC_STAGES-1:0] data_sync_reg;
   logic                   clk_s;
   logic                   data_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync_reg  <= '1;
         data_sync_reg <= '1;
      end else begin
         clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk};
         data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data};
      end
   end

   assign clk_s  = clk_sync_reg[SYNC_STAGES-1];
   assign data_s = data_sync_reg[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Clock deglitch filter: the filtered clock follows only after
   // FILTER_LEN consecutive disagreeing samples; any agreement restarts it.
   // ------------------------------------------------------------------
   logic          filt_reg;
   logic          filt_d_reg;
   logic [FW-1:0] filt_cnt_reg;
   logic          fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_reg     <= 1'b1;
         filt_d_reg   <= 1'b1;
         filt_cnt_reg <= '0;
      end else begin
         filt_d_reg <= filt_reg;
         if (clk_s != filt_reg) begin
            if (filt_cnt_reg == FILT_MAX) begin
               filt_reg     <= clk_s;
               filt_cnt_reg <= '0;
            end else begin
               filt_cnt_reg <= filt_cnt_reg + FW'(1);
            end
         end else begin
            filt_cnt_reg <= '0;
         end
      end
   end

   // One-cycle pulse in the cycle after the filtered clock drops.
   assign fall = filt_d_reg & ~filt_reg;

   // ------------------------------------------------------------------
   // Frame state machine
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   state_t      state_reg, state_next;
   logic [2:0]  bit_cnt_reg, bit_cnt_next;
   logic [7:0]  shift_reg, shift_next;
   logic        par_reg, par_next;
   logic        accept;
   logic        set_parity;
   logic        set_frame;
   logic        wd_expire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= S_IDLE;
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
         par_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         bit_cnt_reg <= bit_cnt_next;
         shift_reg   <= shift_next;
         par_reg     <= par_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      bit_cnt_next = bit_cnt_reg;
      shift_next   = shift_reg;
      par_next     = par_reg;
      accept       = 1'b0;
      set_parity   = 1'b0;
      set_frame    = 1'b0;
      if (fall) begin
         case (state_reg)
            S_IDLE: begin
               // A high start bit is noise; stay idle without flagging.
               if (!data_s) begin
                  state_next   = S_DATA;
                  bit_cnt_next = 3'd0;
               end
            end
            S_DATA: begin
               shift_next   = {data_s, shift_reg[7:1]};
               bit_cnt_next = bit_cnt_reg + 3'd1;
               if (bit_cnt_reg == 3'd7) begin
                  state_next = S_PARITY;
               end
            end
            S_PARITY: begin
               par_next   = data_s;
               state_next = S_STOP;
            end
            S_STOP: begin
               state_next = S_IDLE;
               if (!data_s) begin
                  set_frame = 1'b1;
               end else if (^{shift_reg, par_reg} == 1'b0) begin
                  set_parity = 1'b1;
               end else begin
                  accept = 1'b1;
               end
            end
            default: state_next = S_IDLE;
         endcase
      end
      // Watchdog never fires in a fall cycle, so it cannot race an accept.
      if (wd_expire) begin
         state_next = S_IDLE;
      end
   end

   // ------------------------------------------------------------------
   // Optional frame watchdog
   // ------------------------------------------------------------------
`ifdef PS2_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES);
   localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES - 1);

   logic [WW-1:0] wd_cnt_reg;
   logic          timeout_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt_reg <= '0;
      end else if (state_reg == S_IDLE || fall) begin
         wd_cnt_reg <= '0;
      end else begin
         wd_cnt_reg <= wd_cnt_reg + WW'(1);
      end
   end

   assign wd_expire = (state_reg != S_IDLE) && !fall && (wd_cnt_reg == WD_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timeout_reg <= 1'b0;
      end else begin
         timeout_reg <= wd_expire | (timeout_reg & ~err_clr);
      end
   end

   assign timeout = timeout_reg;
`else
   assign wd_expire = 1'b0;
   assign timeout   = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Sticky error flags
   // ------------------------------------------------------------------
   logic parity_err_reg;
   logic frame_err_reg;
   logic overflow_reg;
   logic push;
   logic pop;
   logic drop;

   assign push = accept & (~full | rd);
   assign drop = accept & full & ~rd;
   assign pop  = rd & ~empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_err_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
         overflow_reg   <= 1'b0;
      end else begin
         parity_err_reg <= set_parity | (parity_err_reg & ~err_clr);
         frame_err_reg  <= set_frame  | (frame_err_reg  & ~err_clr);
         overflow_reg   <= drop       | (overflow_reg   & ~err_clr);
      end
   end

   assign parity_err = parity_err_reg;
   assign frame_err  = frame_err_reg;
   assign overflow   = overflow_reg;

   // ------------------------------------------------------------------
   // History register; updated on every accepted byte, even one the
   // FIFO has to drop.
   // ------------------------------------------------------------------
   logic [8*HIST-1:0] code_reg;
   logic [8*HIST-1:0] code_next;

   generate
      if (HIST == 1) begin : g_hist_one
         assign code_next = shift_reg;
      end else begin : g_hist_many
         assign code_next = {shift_reg, code_reg[8*HIST-1:8]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_reg <= '0;
      end else if (accept) begin
         code_reg <= code_next;
      end
   end

   assign code = code_reg;

   // ------------------------------------------------------------------
   // FWFT FIFO. Pointers are AW bits wide and wrap naturally because
   // DEPTH is a power of two. On a full push+pop the write lands on the
   // slot being vacated in the same edge.
   // ------------------------------------------------------------------
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= shift_reg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign empty = (count_reg == '0);
   assign full  = (count_reg == FULL_CNT);
   assign count = count_reg;
   assign dout  = empty ? 8'h00 : mem[rd_ptr_reg];

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_ps2_rx_fifo
// Self-checking bench for ps2_rx_fifo. PS/2 frames are bit-banged on the
// pins; every good frame pushes its byte to a scoreboard queue that models
// the FIFO contents, and each pop compares dout with the queue head.
// The watchdog scenario runs only when PS2_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_ps2_rx_fifo;

   localparam int DEPTH = 8;

   logic        clk;
   logic        rst_n;
   logic        ps2_clk;
   logic        ps2_data;
   logic        rd;
   logic        err_clr;
   logic [7:0]  dout;
   logic        empty;
   logic        full;
   logic [3:0]  count;
   logic [15:0] code;
   logic        parity_err;
   logic        frame_err;
   logic        overflow;
   logic        timeout;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  sb[$];
   logic [15:0] code_model;
   logic        ovf_model;

   ps2_rx_fifo #(
      .DEPTH(DEPTH), .SYNC_STAGES(2), .FILTER_LEN(4), .HIST(2), .TIMEOUT_CYCLES(1000)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .rd(rd), .err_clr(err_clr), .dout(dout), .empty(empty), .full(full),
      .count(count), .code(code), .parity_err(parity_err), .frame_err(frame_err),
      .overflow(overflow), .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] stuck");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end else begin
         $display("[TB] ok %s = %0h", tag, act);
      end
   endtask

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pop_check(input string tag);
      logic [7:0] exp;
      check({tag, "_nonempty"}, 32'(empty), 32'(0));
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: scoreboard empty, dout=%0h", tag, dout);
      end else begin
         exp = sb.pop_front();
         check(tag, 32'(dout), 32'(exp));
      end
      rd = 1'b1;
      hold(1);
      rd = 1'b0;
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      hold(1);
      err_clr = 1'b0;
   endtask

   // Full frame. glitch adds 2-cycle low blips during two high phases;
   // rd_at_stop raises rd exactly on the edge where the stop bit is taken.
   task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_bit,
                             input bit glitch, input bit rd_at_stop);
      logic [10:0] bits;
      logic        par;
      par  = ~(^b) ^ par_flip;
      bits = {stop_bit, par, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         ps2_data = bits[i];
         hold(10);
         ps2_clk = 1'b0;
         if (i == 10 && rd_at_stop) begin
            // Pin fall -> stop-bit edge is 7 clk edges (2 sync + 4 filter + 1).
            hold(6);
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL rd_at_stop: scoreboard empty");
            end else begin
               check("dout_at_push_pop", 32'(dout), 32'(sb.pop_front()));
            end
            rd = 1'b1;
            hold(1);
            rd = 1'b0;
            hold(13);
         end else begin
            hold(20);
         end
         ps2_clk = 1'b1;
         if (glitch && (i == 3 || i == 6)) begin
            hold(10);
            ps2_clk = 1'b0;
            hold(2);
            ps2_clk = 1'b1;
            hold(10);
         end else begin
            hold(10);
         end
      end
      ps2_data = 1'b1;
      if (stop_bit && !par_flip) begin
         code_model = {b, code_model[15:8]};
         if (sb.size() < DEPTH) sb.push_back(b);
         else ovf_model = 1'b1;
      end
   endtask

   // Start bit plus nbits data bits, then the clock stays high.
   task automatic send_partial(input logic [7:0] b, input int nbits);
      logic [8:0] bits;
      bits = {b, 1'b0};
      for (int i = 0; i <= nbits; i++) begin
         ps2_data = bits[i];
         hold(10);
         ps2_clk = 1'b0;
         hold(20);
         ps2_clk = 1'b1;
         hold(10);
      end
      ps2_data = 1'b1;
   endtask

   initial begin
      rst_n      = 1'b0;
      ps2_clk    = 1'b1;
      ps2_data   = 1'b1;
      rd         = 1'b0;
      err_clr    = 1'b0;
      code_model = 16'h0000;
      ovf_model  = 1'b0;
      hold(3);
      rst_n = 1'b1;
      hold(2);

      // Reset state
      check("rst_dout", 32'(dout), 32'(0));
      check("rst_empty", 32'(empty), 32'(1));
      check("rst_full", 32'(full), 32'(0));
      check("rst_count", 32'(count), 32'(0));
      check("rst_code", 32'(code), 32'(0));
      check("rst_flags", 32'({parity_err, frame_err, overflow, timeout}), 32'(0));

      // Two good bytes, no reads
      send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
      check("two_count", 32'(count), 32'(sb.size()));
      check("two_code", 32'(code), 32'(code_model));
      pop_check("pop_f0");
      check("one_count", 32'(count), 32'(sb.size()));
      pop_check("pop_1c");
      check("drained_empty", 32'(empty), 32'(1));

      // Bad parity
      send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
      check("par_empty", 32'(empty), 32'(1));
      check("par_err_set", 32'(parity_err), 32'(1));
      check("par_code_kept", 32'(code), 32'(code_model));
      pulse_clr();
      check("par_err_clr", 32'(parity_err), 32'(0));

      // Bad stop bit
      send_frame(8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
      check("frm_err_set", 32'(frame_err), 32'(1));
      check("frm_empty", 32'(empty), 32'(1));
      check("frm_par_clean", 32'(parity_err), 32'(0));
      pulse_clr();
      check("frm_err_clr", 32'(frame_err), 32'(0));

      // Overflow: 9 bytes into 8 slots
      for (int i = 1; i <= 9; i++) begin
         send_frame(8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
      end
      check("ovf_full", 32'(full), 32'(1));
      check("ovf_count", 32'(count), 32'(DEPTH));
      check("ovf_flag", 32'(overflow), 32'(ovf_model));
      check("ovf_code", 32'(code), 32'(code_model));
      pulse_clr();
      check("ovf_clr", 32'(overflow), 32'(0));
      for (int i = 0; i < DEPTH; i++) pop_check($sformatf("ovf_pop%0d", i));
      check("ovf_drained", 32'(empty), 32'(1));

      // Full FIFO with rd on the push edge: the new byte is accepted
      ovf_model = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         send_frame(8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
      end
      send_frame(8'h09, 1'b0, 1'b1, 1'b0, 1'b1);
      check("rdpush_overflow", 32'(overflow), 32'(ovf_model));
      check("rdpush_count", 32'(count), 32'(sb.size()));
      check("rdpush_full", 32'(full), 32'(1));
      for (int i = 0; i < DEPTH; i++) pop_check($sformatf("rdpush_pop%0d", i));
      check("rdpush_empty", 32'(empty), 32'(1));

      // Clock glitches inside a frame
      send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
      check("glitch_count", 32'(count), 32'(1));
      check("glitch_flags", 32'({parity_err, frame_err}), 32'(0));
      pop_check("glitch_5a");
      check("glitch_empty", 32'(empty), 32'(1));

`ifdef PS2_TIMEOUT_EN
      // Stalled frame is aborted by the watchdog
      send_partial(8'h5A, 3);
      hold(1100);
      check("to_flag", 32'(timeout), 32'(1));
      check("to_empty", 32'(empty), 32'(1));
      pulse_clr();
      check("to_clr", 32'(timeout), 32'(0));
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
      check("to_after_code", 32'(code), 32'(code_model));
      pop_check("to_after_5a");
`endif

      // Reset in the middle of a frame
      send_partial(8'hA5, 4);
      rst_n = 1'b0;
      hold(3);
      rst_n = 1'b1;
      hold(5);
      sb.delete();
      code_model = 16'h0000;
      send_frame(8'h29, 1'b0, 1'b1, 1'b0, 1'b0);
      check("rstmid_count", 32'(count), 32'(1));
      check("rstmid_code", 32'(code), 32'(code_model));
      check("rstmid_flags", 32'({parity_err, frame_err, overflow, timeout}), 32'(0));
      pop_check("rstmid_29");
      check("rstmid_empty", 32'(empty), 32'(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
